// File: rtl/fwrisc_fetch_pkg.sv
// Shared definitions for the fwrisc instruction fetch stage.
//   fetch_state_e  : fetch FSM state encoding
//   is_compressed  : RVC test on the two low bits of an instruction halfword
package fwrisc_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned HLEN = 16;

  typedef enum logic [1:0] {
    FETCH0  = 2'd0,
    FETCH1  = 2'd1,
    PRESENT = 2'd2,
    WAIT_PC = 2'd3
  } fetch_state_e;

  // Any low-bit pattern other than 2'b11 marks a 16-bit instruction.
  function automatic logic is_compressed(input logic [1:0] lo);
    return (lo != 2'b11);
  endfunction

endpackage

// File: rtl/fwrisc_fetch.sv
// Instruction fetch stage feeding fwrisc_exec.
// Fetches 32-bit words at the PC supplied by exec, extracts 16-bit (RVC) or
// 32-bit instructions (including ones straddling two words), and presents one
// instruction until exec reports completion. A one-halfword buffer holds the
// upper half of the last fetched word so sequential compressed code can be
// served without re-reading the same word.
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   pc, pc_seq            next PC from exec; pc_seq=0 marks a discontinuity
//   instr_complete        exec finished the presented instruction
//   instr, instr_c        presented instruction and its compressed flag
//   fetch_valid           instr/instr_c valid
//   iaddr, ivalid         word-aligned bus request
//   irdata, iready        bus read data and accept/data-valid strobe
module fwrisc_fetch
  import fwrisc_fetch_pkg::*;
#(
  parameter int unsigned ENABLE_COMPRESSED = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_seq,
  input  logic            instr_complete,
  output logic [XLEN-1:0] instr,
  output logic            instr_c,
  output logic            fetch_valid,
  output logic [XLEN-1:0] iaddr,
  output logic            ivalid,
  input  logic [XLEN-1:0] irdata,
  input  logic            iready
);

  localparam bit RVC = (ENABLE_COMPRESSED != 0);

  fetch_state_e    state_q, state_d;
  logic            ivalid_q, ivalid_d;
  logic [XLEN-1:0] iaddr_q, iaddr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_c_q, instr_c_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic [HLEN-1:0] hb_data_q, hb_data_d;
  logic [XLEN-1:0] hb_addr_q, hb_addr_d;
  logic            hb_valid_q, hb_valid_d;
  logic [HLEN-1:0] lo_half_q, lo_half_d;

  logic            pc_hi_c;
  logic            hb_hit_c;
  logic            hb_cmp_c;
  logic            bus_done_c;
  logic [HLEN-1:0] sel_half_c;
  logic            sel_cmp_c;
  logic [XLEN-1:0] word_c;

  // Shared decode of the current PC, buffer and bus response.
  assign pc_hi_c    = RVC && pc[1];
  assign hb_hit_c   = RVC && pc_seq && hb_valid_q && (hb_addr_q == pc) && pc[1];
  assign hb_cmp_c   = is_compressed(hb_data_q[1:0]);
  assign bus_done_c = ivalid_q && iready;
  assign sel_half_c = pc_hi_c ? irdata[31:16] : irdata[15:0];
  assign sel_cmp_c  = RVC && is_compressed(sel_half_c[1:0]);
  assign word_c     = {pc[XLEN-1:2], 2'b00};

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= FETCH0;
    else       state_q <= state_d;
  end

  // Next-state logic. In FETCH0, ivalid_q low is the lookup cycle and ivalid_q
  // high means a bus read is outstanding.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH0: begin
        if (!ivalid_q) begin
          if (hb_hit_c) state_d = hb_cmp_c ? PRESENT : FETCH1;
        end else if (iready) begin
          state_d = (pc_hi_c && !sel_cmp_c) ? FETCH1 : PRESENT;
        end
      end
      FETCH1:  if (bus_done_c) state_d = PRESENT;
      PRESENT: if (instr_complete) state_d = WAIT_PC;
      WAIT_PC: state_d = FETCH0;
      default: state_d = FETCH0;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    ivalid_d      = ivalid_q;
    iaddr_d       = iaddr_q;
    instr_d       = instr_q;
    instr_c_d     = instr_c_q;
    fetch_valid_d = fetch_valid_q;
    hb_data_d     = hb_data_q;
    hb_addr_d     = hb_addr_q;
    hb_valid_d    = hb_valid_q;
    lo_half_d     = lo_half_q;
    unique case (state_q)
      FETCH0: begin
        if (!ivalid_q) begin
          // A discontinuity makes the buffered halfword meaningless.
          if (!pc_seq) hb_valid_d = 1'b0;
          if (hb_hit_c) begin
            if (hb_cmp_c) begin
              instr_d       = {16'h0000, hb_data_q};
              instr_c_d     = 1'b1;
              fetch_valid_d = 1'b1;
            end else begin
              lo_half_d = hb_data_q;
              ivalid_d  = 1'b1;
              iaddr_d   = word_c + 32'd4;
            end
          end else begin
            ivalid_d = 1'b1;
            iaddr_d  = word_c;
          end
        end else if (iready) begin
          if (pc_hi_c) begin
            if (sel_cmp_c) begin
              instr_d       = {16'h0000, sel_half_c};
              instr_c_d     = 1'b1;
              fetch_valid_d = 1'b1;
              ivalid_d      = 1'b0;
              hb_valid_d    = 1'b0;
            end else begin
              // Straddling instruction: keep ivalid up and move to the next word.
              lo_half_d = sel_half_c;
              iaddr_d   = iaddr_q + 32'd4;
            end
          end else begin
            instr_d       = sel_cmp_c ? {16'h0000, irdata[15:0]} : irdata;
            instr_c_d     = sel_cmp_c;
            fetch_valid_d = 1'b1;
            ivalid_d      = 1'b0;
            hb_data_d     = irdata[31:16];
            hb_addr_d     = {iaddr_q[XLEN-1:2], 2'b10};
            hb_valid_d    = RVC;
          end
        end
      end
      FETCH1: begin
        if (bus_done_c) begin
          instr_d       = {irdata[15:0], lo_half_q};
          instr_c_d     = 1'b0;
          fetch_valid_d = 1'b1;
          ivalid_d      = 1'b0;
          hb_data_d     = irdata[31:16];
          hb_addr_d     = iaddr_q + 32'd2;
          hb_valid_d    = 1'b1;
        end
      end
      PRESENT: if (instr_complete) fetch_valid_d = 1'b0;
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ivalid_q      <= 1'b0;
      iaddr_q       <= '0;
      instr_q       <= '0;
      instr_c_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
      hb_data_q     <= '0;
      hb_addr_q     <= '0;
      hb_valid_q    <= 1'b0;
      lo_half_q     <= '0;
    end else begin
      ivalid_q      <= ivalid_d;
      iaddr_q       <= iaddr_d;
      instr_q       <= instr_d;
      instr_c_q     <= instr_c_d;
      fetch_valid_q <= fetch_valid_d;
      hb_data_q     <= hb_data_d;
      hb_addr_q     <= hb_addr_d;
      hb_valid_q    <= hb_valid_d;
      lo_half_q     <= lo_half_d;
    end
  end

  assign instr       = instr_q;
  assign instr_c     = instr_c_q;
  assign fetch_valid = fetch_valid_q;
  assign iaddr       = iaddr_q;
  assign ivalid      = ivalid_q;

endmodule

// File: tb/tb_fwrisc_fetch.sv
// Testbench for fwrisc_fetch: memory-backed bus responder, exec-side driver,
// and a scoreboard monitor comparing presented instructions to a reference
// model that decodes instructions straight from the memory image.
module tb_fwrisc_fetch;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned MEM_WORDS = 64;

  typedef struct packed {
    logic [31:0] instr;
    logic        c;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_seq;
  logic        instr_complete;
  logic [31:0] instr;
  logic        instr_c;
  logic        fetch_valid;
  logic [31:0] iaddr;
  logic        ivalid;
  logic [31:0] irdata;
  logic        iready;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mem [MEM_WORDS];
  exp_t        exp_q [$];
  logic [31:0] rd_log [$];
  int          iv_cycles = 0;
  int          bus_delay = 0;
  bit          bus_rand = 1'b0;

  fwrisc_fetch #(.ENABLE_COMPRESSED(1)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .pc_seq         (pc_seq),
    .instr_complete (instr_complete),
    .instr          (instr),
    .instr_c        (instr_c),
    .fetch_valid    (fetch_valid),
    .iaddr          (iaddr),
    .ivalid         (ivalid),
    .irdata         (irdata),
    .iready         (iready)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] mem_half(input logic [31:0] a);
    logic [31:0] off;
    logic [31:0] w;
    off = a - BASE;
    w = mem[off[7:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference: a halfword with low bits != 11 is a whole RVC instruction,
  // otherwise the instruction is that halfword plus the following one.
  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    logic [15:0] lo;
    lo = mem_half(a);
    if (lo[1:0] != 2'b11) begin
      e.instr = {16'h0000, lo};
      e.c     = 1'b1;
    end else begin
      e.instr = {mem_half(a + 32'd2), lo};
      e.c     = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
    return h;
  endfunction

  // Bus responder: answers each request after a delay, checks request stability,
  // and throws stray iready pulses while no request is pending.
  initial begin : responder
    bit          pending;
    logic [31:0] req_addr;
    logic [31:0] off;
    int          cnt;
    pending  = 1'b0;
    req_addr = '0;
    cnt      = 0;
    iready   = 1'b0;
    irdata   = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pending = 1'b0;
        iready  = 1'b0;
      end else if (ivalid) begin
        iv_cycles++;
        if (!pending) begin
          pending  = 1'b1;
          req_addr = iaddr;
          cnt      = bus_rand ? int'($urandom_range(0, 3)) : bus_delay;
          chk("iaddr_aligned", {30'b0, iaddr[1:0]}, 32'd0);
        end else begin
          chk("iaddr_stable", iaddr, req_addr);
        end
        if (cnt == 0) begin
          off    = req_addr - BASE;
          iready = 1'b1;
          irdata = mem[off[7:2]];
          rd_log.push_back(req_addr);
          pending = 1'b0;
        end else begin
          cnt--;
          iready = 1'b0;
          irdata = $urandom;
        end
      end else begin
        pending = 1'b0;
        iready  = ($urandom_range(0, 3) == 0);
        irdata  = $urandom;
      end
    end
  end

  // Scoreboard monitor: pops an expectation on each fetch_valid rise and checks
  // the presented instruction is held while fetch_valid stays high.
  initial begin : monitor
    bit          prev_fv;
    exp_t        e;
    logic [31:0] held_i;
    logic        held_c;
    prev_fv = 1'b0;
    held_i  = '0;
    held_c  = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_fv = 1'b0;
      end else begin
        if (fetch_valid && !prev_fv) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_present: got 0x%08h expected no instruction", instr);
          end else begin
            e = exp_q.pop_front();
            chk("instr", instr, e.instr);
            chk("instr_c", {31'b0, instr_c}, {31'b0, e.c});
          end
          held_i = instr;
          held_c = instr_c;
        end else if (fetch_valid) begin
          chk("instr_hold", instr, held_i);
          chk("instr_c_hold", {31'b0, instr_c}, {31'b0, held_c});
        end
        prev_fv = fetch_valid;
      end
    end
  end

  // Wait (from a negedge) for fetch_valid; optionally check the edge count.
  task automatic wait_fv(input int start_edges, input int exp_lat, input string name);
    int edges;
    edges = start_edges;
    while (!fetch_valid && edges < 60) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    if (!fetch_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no fetch_valid after %0d edges, required within 60", name, edges);
    end else if (exp_lat > 0) begin
      chk(name, 32'(edges), 32'(exp_lat));
    end
  endtask

  // Exec side: complete the presented instruction, then supply the next PC.
  task automatic next_instr(input logic [31:0] npc, input logic seq, input int exp_lat,
                            input string name);
    instr_complete = 1'b1;
    @(posedge clock);
    @(negedge clock);
    instr_complete = 1'b0;
    pc     = npc;
    pc_seq = seq;
    exp_q.push_back(model(npc));
    rd_log.delete();
    iv_cycles = 0;
    wait_fv(1, exp_lat, name);
  endtask

  initial begin : main
    logic [31:0] cur;
    logic [31:0] nxt;
    logic        seq;
    exp_t        e;
    int          r;
    int          tries;

    reset = 1'b1;
    pc = BASE;
    pc_seq = 1'b0;
    instr_complete = 1'b0;
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = '0;
    mem[0] = 32'h0050_0093;
    repeat (3) @(negedge clock);
    chk("rst_ivalid", {31'b0, ivalid}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_c", {31'b0, instr_c}, 32'd0);

    // Aligned 32-bit miss, iready in the first bus cycle.
    exp_q.push_back(model(BASE));
    rd_log.delete();
    reset = 1'b0;
    wait_fv(0, 2, "t1_latency");
    chk("t1_nreads", 32'(rd_log.size()), 32'd1);
    chk("t1_iaddr", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFF_FFFF, BASE);

    // Two RVC in one word; second served from the halfword buffer.
    mem[0] = 32'h00A2_4501;
    next_instr(BASE, 1'b0, 4, "t2a_latency");
    chk("t2a_nreads", 32'(rd_log.size()), 32'd1);
    next_instr(BASE + 32'd2, 1'b1, 3, "t2b_latency");
    chk("t2b_nreads", 32'(rd_log.size()), 32'd0);
    chk("t2b_ivalid_cycles", 32'(iv_cycles), 32'd0);

    // 32-bit instruction straddling words 1 and 2.
    mem[1] = 32'h0093_1234;
    mem[2] = 32'hABCD_0050;
    next_instr(BASE + 32'd6, 1'b0, 5, "t3_latency");
    chk("t3_nreads", 32'(rd_log.size()), 32'd2);
    chk("t3_iaddr0", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFF_FFFF, BASE + 32'd4);
    chk("t3_iaddr1", (rd_log.size() > 1) ? rd_log[1] : 32'hFFFF_FFFF, BASE + 32'd8);

    // Valid buffer for BASE+2, but pc_seq=0 forces a refetch.
    next_instr(BASE, 1'b0, 4, "t4a_latency");
    next_instr(BASE + 32'd2, 1'b0, 4, "t4b_latency");
    chk("t4_nreads", 32'(rd_log.size()), 32'd1);
    chk("t4_iaddr", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFF_FFFF, BASE);

    // iready delayed by three cycles.
    bus_delay = 3;
    next_instr(BASE, 1'b0, 7, "t5_latency");
    chk("t5_ivalid_cycles", 32'(iv_cycles), 32'd4);
    chk("t5_nreads", 32'(rd_log.size()), 32'd1);

    // Reset while the second read of a straddle is outstanding.
    instr_complete = 1'b1;
    @(posedge clock);
    @(negedge clock);
    instr_complete = 1'b0;
    pc = BASE + 32'd6;
    pc_seq = 1'b0;
    tries = 0;
    while (!(ivalid && iaddr == BASE + 32'd8) && tries < 30) begin
      @(posedge clock);
      @(negedge clock);
      tries++;
    end
    chk("t6_in_fetch1", {31'b0, (ivalid && iaddr == BASE + 32'd8)}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_ivalid_reset", {31'b0, ivalid}, 32'd0);
    chk("t6_fetch_valid_reset", {31'b0, fetch_valid}, 32'd0);
    exp_q.delete();
    bus_delay = 0;
    pc = BASE;
    @(negedge clock);
    @(negedge clock);
    exp_q.push_back(model(BASE));
    rd_log.delete();
    reset = 1'b0;
    wait_fv(0, 2, "t6_restart_latency");
    chk("t6_iaddr", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFF_FFFF, BASE);

    // Random program with random bus delays, sequential flow and jumps.
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = {rand_half(), rand_half()};
    bus_rand = 1'b1;
    cur = BASE + 32'h10;
    next_instr(cur, 1'b0, 0, "rnd");
    for (int n = 0; n < 250; n++) begin
      e = model(cur);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      r   = int'($urandom_range(0, 9));
      nxt = cur + (e.c ? 32'd2 : 32'd4);
      seq = 1'b1;
      if (r < 2 || (nxt - BASE) > 32'd236) begin
        nxt = BASE + 32'(2 * $urandom_range(0, 118));
        seq = 1'b0;
      end else if (r == 2) begin
        seq = 1'b0;
      end
      next_instr(nxt, seq, 0, "rnd");
      cur = nxt;
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
